// File: rtl/mem_cmd_arbiter_if.sv
// mem_cmd_arbiter_if: bundles the two requester handshakes (A = program
// loader, B = core fetch) and the command-BSRAM pin group.
//   slave  modport : arbiter side (takes requests, drives BSRAM pins)
//   master modport : environment side (requesters + BSRAM read data)
interface mem_cmd_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
);
  logic              a_req, a_wre, a_ack;
  logic [ADDR_W-1:0] a_ad;
  logic [DATA_W-1:0] a_din, a_dout;
  logic              b_req, b_wre, b_ack;
  logic [ADDR_W-1:0] b_ad;
  logic [DATA_W-1:0] b_din, b_dout;
  logic [DATA_W-1:0] mem_cmd_dout, mem_cmd_din;
  logic [ADDR_W-1:0] mem_cmd_ad;
  logic              mem_cmd_ce, mem_cmd_wre, mem_cmd_oce, mem_cmd_clk;
  logic              busy, grant;

  modport slave (
    input  a_req, a_wre, a_ad, a_din, b_req, b_wre, b_ad, b_din, mem_cmd_dout,
    output a_ack, a_dout, b_ack, b_dout,
           mem_cmd_din, mem_cmd_ad, mem_cmd_ce, mem_cmd_wre, mem_cmd_oce,
           mem_cmd_clk, busy, grant
  );

  modport master (
    output a_req, a_wre, a_ad, a_din, b_req, b_wre, b_ad, b_din, mem_cmd_dout,
    input  a_ack, a_dout, b_ack, b_dout,
           mem_cmd_din, mem_cmd_ad, mem_cmd_ce, mem_cmd_wre, mem_cmd_oce,
           mem_cmd_clk, busy, grant
  );
endinterface

// File: rtl/mem_cmd_arbiter.sv
// mem_cmd_arbiter: shares the single command-BSRAM port between port A
// (program loader) and port B (core fetch). Each grant runs one fixed
// SETUP / CLKH / CLKL access, then an ACK cycle with a one-cycle ack pulse.
// Ports:
//   sysclk          system clock, rising edge
//   arduino_reset_n synchronous active-low reset
//   bus             mem_cmd_arbiter_if.slave (requesters + BSRAM pins)
// Every output is a register; the comb process computes next values.
module mem_cmd_arbiter #(
  parameter int ADDR_W         = 14,
  parameter int DATA_W         = 8,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic                sysclk,
  input  logic                arduino_reset_n,
  mem_cmd_arbiter_if.slave    bus
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_CLKH, S_CLKL, S_ACK} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_grant, w_grant_nxt;
  logic              r_last, w_last_nxt;   // owner of last completed access
  logic              r_wre, w_wre_nxt;     // latched access direction
  logic [ADDR_W-1:0] r_ad, w_ad_nxt;
  logic [DATA_W-1:0] r_din, w_din_nxt;
  logic              r_ce, w_ce_nxt;
  logic              r_mwre, w_mwre_nxt;
  logic              r_oce, w_oce_nxt;
  logic              r_clk, w_clk_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_a_ack, w_a_ack_nxt, r_b_ack, w_b_ack_nxt;
  logic [DATA_W-1:0] r_a_dout, w_a_dout_nxt, r_b_dout, w_b_dout_nxt;
  logic              w_pick_b;
  logic              w_sel_wre;

  // On a tie the port that did not own the last access wins (round-robin),
  // unless A is given fixed priority.
  always_comb begin
    if (bus.a_req && bus.b_req) w_pick_b = FIXED_PRIORITY ? 1'b0 : ~r_last;
    else                        w_pick_b = bus.b_req;
  end

  assign w_sel_wre = w_pick_b ? bus.b_wre : bus.a_wre;

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_last_nxt   = r_last;
    w_wre_nxt    = r_wre;
    w_ad_nxt     = r_ad;
    w_din_nxt    = r_din;
    w_ce_nxt     = r_ce;
    w_mwre_nxt   = r_mwre;
    w_oce_nxt    = r_oce;
    w_clk_nxt    = r_clk;
    w_a_ack_nxt  = 1'b0;
    w_b_ack_nxt  = 1'b0;
    w_a_dout_nxt = r_a_dout;
    w_b_dout_nxt = r_b_dout;
    case (r_state)
      S_IDLE: if (bus.a_req || bus.b_req) begin
        // Pins take the winner's command on entry to SETUP; the pin
        // registers double as the latched address/data.
        w_grant_nxt = w_pick_b;
        w_wre_nxt   = w_sel_wre;
        w_ad_nxt    = w_pick_b ? bus.b_ad : bus.a_ad;
        if (w_sel_wre) w_din_nxt = w_pick_b ? bus.b_din : bus.a_din;
        w_ce_nxt    = 1'b1;
        w_mwre_nxt  = w_sel_wre;
        w_oce_nxt   = ~w_sel_wre;
        w_state_nxt = S_SETUP;
      end
      S_SETUP: begin
        w_clk_nxt   = 1'b1;
        w_state_nxt = S_CLKH;
      end
      S_CLKH: begin
        w_clk_nxt   = 1'b0;
        w_ce_nxt    = 1'b0;
        w_mwre_nxt  = 1'b0;
        w_oce_nxt   = 1'b0;
        w_state_nxt = S_CLKL;
      end
      S_CLKL: begin
        // BSRAM read data is valid after the CLKH rising edge.
        if (!r_wre) begin
          if (r_grant) w_b_dout_nxt = bus.mem_cmd_dout;
          else         w_a_dout_nxt = bus.mem_cmd_dout;
        end
        w_a_ack_nxt = ~r_grant;
        w_b_ack_nxt = r_grant;
        w_last_nxt  = r_grant;
        w_state_nxt = S_ACK;
      end
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge sysclk) begin
    if (!arduino_reset_n) begin
      r_state  <= S_IDLE;
      r_grant  <= 1'b0;
      r_last   <= 1'b1;  // B, so A wins the first tie
      r_wre    <= 1'b0;
      r_ad     <= '0;
      r_din    <= '0;
      r_ce     <= 1'b0;
      r_mwre   <= 1'b0;
      r_oce    <= 1'b0;
      r_clk    <= 1'b0;
      r_busy   <= 1'b0;
      r_a_ack  <= 1'b0;
      r_b_ack  <= 1'b0;
      r_a_dout <= '0;
      r_b_dout <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_last   <= w_last_nxt;
      r_wre    <= w_wre_nxt;
      r_ad     <= w_ad_nxt;
      r_din    <= w_din_nxt;
      r_ce     <= w_ce_nxt;
      r_mwre   <= w_mwre_nxt;
      r_oce    <= w_oce_nxt;
      r_clk    <= w_clk_nxt;
      r_busy   <= w_busy_nxt;
      r_a_ack  <= w_a_ack_nxt;
      r_b_ack  <= w_b_ack_nxt;
      r_a_dout <= w_a_dout_nxt;
      r_b_dout <= w_b_dout_nxt;
    end
  end

  assign bus.mem_cmd_ad  = r_ad;
  assign bus.mem_cmd_din = r_din;
  assign bus.mem_cmd_ce  = r_ce;
  assign bus.mem_cmd_wre = r_mwre;
  assign bus.mem_cmd_oce = r_oce;
  assign bus.mem_cmd_clk = r_clk;
  assign bus.busy        = r_busy;
  assign bus.grant       = r_grant;
  assign bus.a_ack       = r_a_ack;
  assign bus.b_ack       = r_b_ack;
  assign bus.a_dout      = r_a_dout;
  assign bus.b_dout      = r_b_dout;

endmodule

// File: doc/mem_cmd_arbiter.md
Name: mem_cmd_arbiter

Overview:
- Shares the single command-memory BSRAM port between two requesters: port A (Arduino-side program loader) and port B (processor core fetch).
- Each requester uses a req/ack handshake.
- Arbiter sequences the BSRAM port with a fixed setup / clock-high / clock-low access: one memory access per grant.
- Sits between both requesters and the mem_cmd_* pins of the command BSRAM.

Parameters:
- ADDR_W, 14, command memory address width
- DATA_W, 8, command memory data width
- FIXED_PRIORITY, 0, 0 = round-robin on contention; 1 = port A always wins contention

Ports:
- sysclk  in  1  system clock, all logic on rising edge
- arduino_reset_n  in  1  synchronous, active-low reset
- a_req  in  1  port A access request
- a_wre  in  1  port A: 1 = write, 0 = read
- a_ad  in  ADDR_W  port A address
- a_din  in  DATA_W  port A write data
- a_ack  out  1  port A one-cycle completion pulse
- a_dout  out  DATA_W  port A read data
- b_req, b_wre, b_ad, b_din, b_ack, b_dout  same as port A, for port B
- mem_cmd_dout  in  DATA_W  BSRAM read data
- mem_cmd_din  out  DATA_W  BSRAM write data
- mem_cmd_ad  out  ADDR_W  BSRAM address
- mem_cmd_ce  out  1  BSRAM clock enable
- mem_cmd_wre  out  1  BSRAM write enable
- mem_cmd_oce  out  1  BSRAM output clock enable
- mem_cmd_clk  out  1  BSRAM clock, generated by state machine
- busy  out  1  high whenever state != IDLE
- grant  out  1  0 = A, 1 = B; owner of current or last access

Behaviour:
- Reset (arduino_reset_n low at a rising edge) dominates everything, including mid-access:
  - state = IDLE.
  - All outputs 0: mem_cmd_*, a_ack, b_ack, a_dout, b_dout, busy, grant.
  - Internal last_grant = B, so A wins the first tie.
- Clock/reset are the only async-free inputs; all outputs are registered.
- State machine, one cycle per state:
  - IDLE:
    - If neither req is high, stay.
    - Else pick winner: single requester wins; if both requesting, A wins when FIXED_PRIORITY=1, otherwise the port != last_grant wins.
    - Latch winner's wre/ad/din internally; set grant; go to SETUP.
  - SETUP:
    - Drive mem_cmd_ad = latched ad; mem_cmd_din = latched din (write) or hold previous (read).
    - mem_cmd_ce = 1; mem_cmd_wre = latched wre; mem_cmd_oce = !latched wre.
    - Go to CLKH.
  - CLKH: mem_cmd_clk = 1; go to CLKL.
  - CLKL:
    - mem_cmd_clk = 0; ce = 0; wre = 0; oce = 0.
    - Read: capture mem_cmd_dout into granted port's dout register. Write: dout unchanged.
    - Set granted port's ack = 1; last_grant = grant; go to ACK.
  - ACK: ack high this cycle only; cleared on leaving; go to IDLE.
- mem_cmd_ad / mem_cmd_din hold their last values outside an access.
- Latency: req high in IDLE cycle T gives ack high in cycle T+4. Read data is valid in the ack cycle and held until the same port's next read completes.
- Throughput: one access per 5 cycles; the loser waits at most one access when round-robin is enabled.
- Handshake rules:
  - Requester holds req, wre, ad, din stable from req rise until ack.
  - Requester drops req on the edge ending the ack cycle.
  - req still high in the following IDLE cycle is a new request (back-to-back allowed).
- req dropping before ack is illegal. The arbiter ignores it: the latched access completes and ack still pulses.
- Never both acks high together; never ack without a preceding grant.
- Other port's req rising mid-access: it is only considered in the next IDLE.
- Address wrap: none; the address is passed through unmodified.

Test Plan:
- Reset: hold arduino_reset_n=0 for 3 cycles with a_req=b_req=1 -> all outputs 0, state IDLE; release -> A granted first (grant=0), a_ack at T+4.
- A read: preload BSRAM[0x0005]=0x3C; a_req=1, a_wre=0, a_ad=0x0005 -> ce/oce high SETUP–CLKH, clk high only in CLKH, a_dout=0x3C with a_ack single pulse at T+4; b_ack stays 0.
- B write then read: b_wre=1, b_ad=0x3FFF, b_din=0xA5 -> wre=1, oce=0, din=0xA5 during access, b_ack at T+4; then a B read of 0x3FFF returns 0xA5; b_dout unchanged after the write ack.
- Contention, FIXED_PRIORITY=0: both req held continuously for 4 accesses -> grants A,B,A,B, acks every 5 cycles. With FIXED_PRIORITY=1 -> grants A,A,A,A and B starves.
- Reset mid-access: assert arduino_reset_n=0 during CLKH -> next cycle mem_cmd_clk=0, ce=0, no ack issued, dout unchanged (0), busy=0.
- Illegal early drop: a_req falls in SETUP -> access still completes, a_ack pulses once, no second access started.
